// File: rtl/display_pkg.sv
// display_pkg: shared constants and hex-to-segment table for the instruction display.
package display_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] DIGIT_OFF = 8'hFF;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return HEX_SEG[n];
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw pushbutton, debounces it and emits a one-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1_q, sync2_q, level_q, level_d, rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The count only runs while the synchronized level differs from the accepted one,
  // so any bounce back to the accepted level restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q <= rise_d;
      cnt_q <= cnt_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/instr_display_scanner.sv
// instr_display_scanner: snapshots pipeline instructions and scans them as 8 hex digits onto a seven-segment bank.
module instr_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LEADING_ZERO_BLANK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        freeze_btn,
  output logic [6:0]  segments,
  output logic [7:0]  digit_en,
  output logic        dp,
  output logic        frozen,
  output logic [15:0] capture_count
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [31:0] snap_q, snap_d, shifted;
  logic [15:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic frozen_q, frozen_d, dp_q, dp_d, cap, tc, blank, btn_rise;
  logic [6:0] seg_q, seg_d;
  logic [7:0] en_q, en_d;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock(clock),
    .reset(reset),
    .btn(freeze_btn),
    .rise(btn_rise)
  );
  // Display registers use the current index and snapshot together, so all pins switch in one edge.
  always_comb begin
    cap = instr_valid & ~frozen_q;
    snap_d = cap ? instr : snap_q;
    cnt_d = cnt_q + 16'(cap);
    tc = pre_q == PW'(REFRESH_DIV - 1);
    pre_d = tc ? '0 : pre_q + 1'b1;
    idx_d = tc ? idx_q + 1'b1 : idx_q;
    frozen_d = frozen_q ^ btn_rise;
    shifted = snap_q >> {idx_q, 2'b00};
    blank = LEADING_ZERO_BLANK != 0 && idx_q != '0 && shifted == '0;
    seg_d = blank ? SEG_BLANK : hex_to_seg(shifted[3:0]);
    en_d = DIGIT_OFF ^ (8'b1 << idx_q);
    dp_d = ~(frozen_q && idx_q == '0);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      frozen_q <= 1'b0;
      seg_q <= SEG_BLANK;
      en_q <= DIGIT_OFF;
      dp_q <= 1'b1;
    end else begin
      snap_q <= snap_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      frozen_q <= frozen_d;
      seg_q <= seg_d;
      en_q <= en_d;
      dp_q <= dp_d;
    end
  end
  assign segments = seg_q;
  assign digit_en = en_q;
  assign dp = dp_q;
  assign frozen = frozen_q;
  assign capture_count = cnt_q;
endmodule

// File: tb/tb_instr_display_scanner.sv
// tb_instr_display_scanner: scoreboard bench; stimulus queues expected scan slots, a monitor checks each slot.
module tb_instr_display_scanner;
  logic clock = 1'b0, reset = 1'b0, instr_valid = 1'b0, freeze_btn = 1'b0;
  logic [31:0] instr = '0;
  logic [6:0] segments;
  logic [7:0] digit_en;
  logic dp, frozen;
  logic [15:0] capture_count;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  bit active = 0;
  int len = 0;
  logic [7:0] prev_en;

  instr_display_scanner #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8), .LEADING_ZERO_BLANK(1)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .freeze_btn(freeze_btn), .segments(segments), .digit_en(digit_en), .dp(dp),
    .frozen(frozen), .capture_count(capture_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // segs packs digits 7..0, 7 bits each, digit 0 in the low bits
  task automatic push_scan(input logic [55:0] segs, input logic dp0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      one = 8'b1 << i;
      exp_q.push_back({~one, segs[7*i +: 7], (i == 0) ? dp0 : 1'b1});
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d slots left expected 0", exp_q.size());
      exp_q.delete();
      active = 0;
    end
  endtask

  task automatic capture(input logic [31:0] w);
    @(negedge clock);
    instr = w;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic press();
    @(negedge clock);
    freeze_btn = 1'b1;
    repeat (20) @(negedge clock);
    freeze_btn = 1'b0;
    repeat (15) @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (digit_en !== prev_en) begin
      if (!active && exp_q.size() > 0 && digit_en == 8'hFE) active = 1;
      else if (active) chk("slot_len", len, 4);
      if (active) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("scan_en", digit_en, e[15:8]);
        chk("scan_seg", segments, e[7:1]);
        chk("scan_dp", dp, e[0]);
        if (exp_q.size() == 0) active = 0;
      end
      len = 0;
    end
    len++;
    prev_en = digit_en;
  end

  initial begin
    bit changed;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_seg", segments, 7'h7F);
    chk("rst_en", digit_en, 8'hFF);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frozen", frozen, 1'b0);
    chk("rst_count", capture_count, 16'h0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock) #1;
    chk("first_en", digit_en, 8'hFE);
    chk("first_seg", segments, 7'h40);

    capture(32'h0000_0020);
    chk("count_1", capture_count, 16'd1);
    push_scan({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40}, 1'b1);
    wait_drain();

    capture(32'h8C22_0004);
    chk("count_2", capture_count, 16'd2);
    push_scan({7'h00, 7'h46, 7'h24, 7'h24, 7'h40, 7'h40, 7'h40, 7'h19}, 1'b1);
    wait_drain();

    @(negedge clock) freeze_btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clock) #1;
      chk($sformatf("freeze_lat_%0d", k), frozen, k == 11);
    end
    repeat (9) @(negedge clock);
    freeze_btn = 1'b0;
    repeat (15) @(negedge clock);
    chk("frozen_hold", frozen, 1'b1);
    push_scan({7'h00, 7'h46, 7'h24, 7'h24, 7'h40, 7'h40, 7'h40, 7'h19}, 1'b0);
    wait_drain();
    capture(32'hFFFF_FFFF);
    chk("count_frozen", capture_count, 16'd2);
    push_scan({7'h00, 7'h46, 7'h24, 7'h24, 7'h40, 7'h40, 7'h40, 7'h19}, 1'b0);
    wait_drain();
    press();
    chk("unfreeze", frozen, 1'b0);

    changed = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      freeze_btn = (c < 30) && ((c / 3) % 2 == 0);
      if (frozen !== 1'b0) changed = 1;
    end
    chk("bounce_stable", changed, 1'b0);

    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    chk("reset_count", capture_count, 16'd0);
    @(negedge clock);
    instr = 32'h1234_5678;
    instr_valid = 1'b1;
    repeat (65535) @(negedge clock);
    chk("count_ffff", capture_count, 16'hFFFF);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("count_wrap", capture_count, 16'h0);

    capture(32'h1234_5678);
    chk("count_pre_async", capture_count, 16'd1);
    repeat (6) @(negedge clock);
    @(posedge clock) #3;
    reset = 1'b0;
    #1;
    chk("async_seg", segments, 7'h7F);
    chk("async_en", digit_en, 8'hFF);
    chk("async_dp", dp, 1'b1);
    chk("async_count", capture_count, 16'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock) #1;
    chk("resume_en", digit_en, 8'hFE);
    chk("resume_seg", segments, 7'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
